spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 clock  input  1  system clock; all logic is on its rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 spi_sclk  input  1  SPI clock from the Orange Pi (mode 0), asynchronous.
REQ-004 spi_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-005 spi_mosi  input  1  SPI data in, MSB first.
REQ-006 spi_miso  output  1  SPI data out, MSB first.
REQ-007 address  output  6  register bus address, registered.
REQ-008 write_en  output  1  one-cycle register write strobe.
REQ-009 wr_data  output  8  register write data, registered.
REQ-010 read_en  output  1  one-cycle register read strobe.
REQ-011 rd_data  input  8  register read data, valid the cycle after read_en.
REQ-012 busy  output  1  high while a frame is in progress (spi_cs_n low after synchronisation).
REQ-013 frame_err  output  1  one-cycle pulse on a short frame or a command error.

Function
REQ-014 Synchronisation: spi_sclk, spi_cs_n and spi_mosi SHALL each pass through two flops; edges SHALL be detected from the synchronised SCLK against its previous value.
REQ-015 Timing: the block SHALL be correct for SCLK half-period >= 8 clock cycles.
REQ-016 Frame format: 16 bits, MSB first.
- Byte0 = {rw, par, addr[5:0]}; rw=1 is a read.
- Byte1 = write data for a write, or don't-care for a read.
REQ-017 MOSI SHALL be sampled on synchronised SCLK rising edges; MISO SHALL change on falling edges.
REQ-018 States: IDLE, CMD, FETCH, DATA, COMMIT, WAIT_CS.
REQ-019 IDLE -> CMD on a synchronised CS falling edge; the bit counter SHALL be cleared to 0 and spi_miso driven 0.
REQ-020 CMD: on the 8th rising edge, latch addr into address and rw.
- Command accepted and rw=1: go to FETCH.
- Command accepted and rw=0: go to DATA.
- Command rejected (REQ-036): go to WAIT_CS.
REQ-021 FETCH: read_en SHALL pulse in the first FETCH cycle; rd_data SHALL be captured into the shift register on the following cycle; then go to DATA.
REQ-022 Read data out: the 8th falling edge SHALL drive the captured bit7 on spi_miso, and each later falling edge the next bit.
REQ-023 spi_miso SHALL be 0 throughout byte0.
REQ-024 DATA: on the 16th rising edge, a write SHALL go to COMMIT; a read SHALL go to WAIT_CS.
REQ-025 COMMIT: wr_data SHALL hold byte1 and write_en SHALL pulse exactly one cycle; then go to WAIT_CS.
REQ-026 WAIT_CS: additional SCLK edges SHALL be ignored and spi_miso driven 0; a synchronised CS rising edge returns to IDLE.
REQ-027 address and wr_data SHALL hold their last values between frames.
REQ-028 write_en and read_en SHALL never be high in the same cycle; each SHALL occur at most once per frame.
REQ-029 Short frame: CS rising in CMD, FETCH or DATA SHALL return to IDLE, pulse frame_err, and suppress write_en.
REQ-030 A read_en already issued before a short frame is permitted; it is side-effect free.
REQ-031 Address 0x00 and out-of-map addresses SHALL be forwarded unchanged (the decoder drops them).
REQ-032 A CS falling edge that occurs while the block is not in IDLE SHALL NOT start a new frame.

Reset
REQ-033 While reset is high, the FSM SHALL go to IDLE and the bit counter and shift registers SHALL clear.
REQ-034 While reset is high, address=0, wr_data=0, write_en=0, read_en=0, spi_miso=0, busy=0, frame_err=0.
REQ-035 Reset mid-frame SHALL abandon the frame with no write_en; the block SHALL resume at the next CS falling edge after reset deasserts.

Configuration
REQ-036 Macro SPI_CMD_PARITY_EN, when defined:
- par SHALL be odd parity over {rw, addr[5:0]}.
- On mismatch: no read_en or write_en, frame_err pulses at the 8th rising edge, MISO=0 for the rest of the frame.
- When undefined, par SHALL be ignored and every command is accepted.

Verification
REQ-037 Write: frame 0x04,0xC5 (par correct) -> single write_en with address=0x04, wr_data=0xC5, after the 16th edge; no read_en.
REQ-038 Read: frame 0x8F,0x00 with rd_data=0x3A -> read_en once with address=0x0F; MISO byte1 = 0x3A; no write_en.
REQ-039 Short frame: CS high after 11 bits of a write to 0x06 -> frame_err pulse, no write_en, next full frame works.
REQ-040 Parity (SPI_CMD_PARITY_EN): byte0 with bad parity -> no strobes, frame_err pulse, MISO=0x00; without the macro -> same frame is accepted.
REQ-041 Reset mid-frame: reset asserted after 12 bits of a write -> all outputs 0, no write_en; following frame 0x01,0x20 -> write_en with address=0x01, wr_data=0x20.
REQ-042 Overlong frame: 24 SCLKs in a write to 0x38 -> exactly one write_en with wr_data = byte1; later bits ignored.

Source files
------------

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : SPI mode-0 slave that turns 16-bit frames into register-bus
//               read/write strobes. Optional macro SPI_CMD_PARITY_EN enables
//               odd-parity checking of the command byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [5:0] address,
    output logic       write_en,
    output logic [7:0] wr_data,
    output logic       read_en,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DATA    = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_WAIT_CS = 3'd5
    } state_t;

    // Two-flop synchronisers plus a third SCLK/CS stage for edge detection.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [5:0]  address_q, address_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        miso_q, miso_d;
    logic        write_en_q, write_en_d;
    logic        read_en_q, read_en_d;
    logic        frame_err_q, frame_err_d;
    logic        cmd_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            address_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            miso_q      <= 1'b0;
            write_en_q  <= 1'b0;
            read_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            address_q   <= address_d;
            wr_data_q   <= wr_data_d;
            miso_q      <= miso_d;
            write_en_q  <= write_en_d;
            read_en_q   <= read_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        miso_d      = miso_q;
        write_en_d  = 1'b0;
        read_en_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef SPI_CMD_PARITY_EN
        // Command byte {rw, par, addr} must carry an odd number of ones.
        cmd_ok = ^{rx_q[6:0], mosi_sync_q};
`else
        cmd_ok = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 4'd0;
                    rx_d      = 8'd0;
                    tx_d      = 8'd0;
                end
            end
            ST_CMD: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[6:0], mosi_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rw_d      = rx_q[6];
                        address_d = {rx_q[4:0], mosi_sync_q};
                        if (!cmd_ok) begin
                            state_d     = ST_WAIT_CS;
                            frame_err_d = 1'b1;
                        end else if (rx_q[6]) begin
                            state_d   = ST_FETCH;
                            read_en_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_FETCH: begin
                // read_en_q marks the strobe cycle; rd_data is valid the cycle after.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (!read_en_q) begin
                    tx_d    = rd_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[6:0], mosi_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        miso_d  = 1'b0;
                        state_d = rw_q ? ST_WAIT_CS : ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                miso_d     = 1'b0;
                wr_data_d  = rx_q;
                write_en_d = 1'b1;
                state_d    = cs_rise ? ST_IDLE : ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign spi_miso  = miso_q;
    assign address   = address_q;
    assign write_en  = write_en_q;
    assign wr_data   = wr_data_q;
    assign read_en   = read_en_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bridge
// Description : Self-checking bench for spi_reg_bridge (table of SPI frames
//               plus reset and busy sequences). Honours SPI_CMD_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

    localparam int HALF = 10;
    localparam int NV   = 11;

    logic       clock = 1'b0;
    logic       reset;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [5:0] address;
    logic       write_en;
    logic [7:0] wr_data;
    logic       read_en;
    logic [7:0] rd_data;
    logic       busy;
    logic       frame_err;

    spi_reg_bridge dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .address   (address),
        .write_en  (write_en),
        .wr_data   (wr_data),
        .read_en   (read_en),
        .rd_data   (rd_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    // Registered read slave: data appears the cycle after read_en, 0xFF otherwise.
    logic       rd_hold = 1'b0;
    logic [7:0] rd_value;
    always @(posedge clock) rd_hold <= read_en;
    assign rd_data = rd_hold ? rd_value : 8'hFF;

    int         wr_cnt, rd_cnt, err_cnt, both_cnt;
    logic [5:0] wr_addr, rd_addr;
    logic [7:0] wr_val;

    always @(negedge clock) begin
        if (!reset) begin
            if (write_en) begin
                wr_cnt++;
                wr_addr = address;
                wr_val  = wr_data;
            end
            if (read_en) begin
                rd_cnt++;
                rd_addr = address;
            end
            if (frame_err) err_cnt++;
            if (write_en && read_en) both_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Shift nbits of data (MSB-aligned in 24 bits); returns MISO sampled before each rise.
    task automatic shift(input logic [23:0] data, input int nbits, output logic [23:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[23-i];
            wait_clk(HALF);
            rx = {rx[22:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic clear_counts();
        wr_cnt   = 0;
        rd_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " address"},   {26'd0, address}, 32'd0);
        check({tag, " wr_data"},   {24'd0, wr_data}, 32'd0);
        check({tag, " write_en"},  {31'd0, write_en}, 32'd0);
        check({tag, " read_en"},   {31'd0, read_en}, 32'd0);
        check({tag, " spi_miso"},  {31'd0, spi_miso}, 32'd0);
        check({tag, " busy"},      {31'd0, busy}, 32'd0);
        check({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    typedef struct {
        logic [23:0] mosi;
        int          nbits;
        logic [7:0]  rd_val;
        int          exp_wr;
        int          exp_rd;
        int          exp_err;
        logic [5:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [23:0] exp_miso;
    } vec_t;

    vec_t        vecs [NV];
    logic [23:0] rxw;

    initial begin
        vecs[0]  = '{24'h04C500, 16, 8'h00, 1, 0, 0, 6'h04, 8'hC5, 24'h000000};
        vecs[1]  = '{24'h8F0000, 16, 8'h3A, 0, 1, 0, 6'h0F, 8'h00, 24'h00003A};
        vecs[2]  = '{24'h46A500, 11, 8'h00, 0, 0, 1, 6'h06, 8'h00, 24'h000000};
        vecs[3]  = '{24'h012000, 16, 8'h00, 1, 0, 0, 6'h01, 8'h20, 24'h000000};
        vecs[4]  = '{24'h385A77, 24, 8'h00, 1, 0, 0, 6'h38, 8'h5A, 24'h000000};
        vecs[5]  = '{24'h800000, 16, 8'hC3, 0, 1, 0, 6'h00, 8'h00, 24'h0000C3};
        vecs[6]  = '{24'h7F8100, 16, 8'h00, 1, 0, 0, 6'h3F, 8'h81, 24'h000000};
        vecs[7]  = '{24'hE50000, 16, 8'h01, 0, 1, 0, 6'h25, 8'h00, 24'h000001};
        vecs[8]  = '{24'h46A500,  8, 8'h00, 0, 0, 1, 6'h06, 8'h00, 24'h000000};
        vecs[9]  = '{24'h8F0000, 10, 8'h3A, 0, 1, 1, 6'h0F, 8'h00, 24'h000000};
`ifdef SPI_CMD_PARITY_EN
        vecs[10] = '{24'h059900, 16, 8'h00, 0, 0, 1, 6'h05, 8'h00, 24'h000000};
`else
        vecs[10] = '{24'h059900, 16, 8'h00, 1, 0, 0, 6'h05, 8'h99, 24'h000000};
`endif

        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rd_value = 8'h00;
        clear_counts();
        wait_clk(5);
        check_all_zero("reset");
        reset = 1'b0;
        wait_clk(10);

        for (int k = 0; k < NV; k++) begin
            clear_counts();
            rd_value = vecs[k].rd_val;
            cs_low();
            shift(vecs[k].mosi, vecs[k].nbits, rxw);
            cs_high();
            check($sformatf("v%0d write_en count", k), wr_cnt, vecs[k].exp_wr);
            check($sformatf("v%0d read_en count", k), rd_cnt, vecs[k].exp_rd);
            check($sformatf("v%0d frame_err count", k), err_cnt, vecs[k].exp_err);
            check($sformatf("v%0d wr+rd overlap", k), both_cnt, 0);
            if (vecs[k].exp_wr > 0) begin
                check($sformatf("v%0d write address", k), {26'd0, wr_addr}, {26'd0, vecs[k].exp_addr});
                check($sformatf("v%0d wr_data", k), {24'd0, wr_val}, {24'd0, vecs[k].exp_wdata});
            end
            if (vecs[k].exp_rd > 0) begin
                check($sformatf("v%0d read address", k), {26'd0, rd_addr}, {26'd0, vecs[k].exp_addr});
            end
            check($sformatf("v%0d miso bits", k), {8'd0, rxw}, {8'd0, vecs[k].exp_miso});
            check($sformatf("v%0d busy after", k), {31'd0, busy}, 32'd0);
        end

        // Reset in the middle of a write: nothing committed, outputs cleared.
        clear_counts();
        cs_low();
        shift(24'h46A500, 12, rxw);
        check("midframe busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        wait_clk(3);
        check_all_zero("midreset");
        reset = 1'b0;
        wait_clk(4);
        check("midreset busy after", {31'd0, busy}, 32'd0);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
        check("midreset write_en count", wr_cnt, 0);

        clear_counts();
        cs_low();
        shift(24'h012000, 16, rxw);
        cs_high();
        check("post-reset write_en count", wr_cnt, 1);
        check("post-reset address", {26'd0, wr_addr}, 32'h01);
        check("post-reset wr_data", {24'd0, wr_val}, 32'h20);
        check("post-reset frame_err count", err_cnt, 0);
        check("hold address", {26'd0, address}, 32'h01);
        check("hold wr_data", {24'd0, wr_data}, 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
